// File: rtl/lab_common_pkg.sv
// Shared constants and FSM encoding for the lab switch-conditioning blocks.
package lab_common_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 50000;
    localparam int DEBOUNCE_CYCLES_SIM = 4;
    localparam int SYNC_STAGES_DEF     = 2;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } deb_state_e;

endpackage

// File: rtl/debounce_ch.sv
// One switch channel: synchronizer, stability counter, debounced level and edge pulses.
// Define DEBOUNCE_TOGGLE_EN to make the output a toggle latch driven by debounced rising edges.
module debounce_ch
    import lab_common_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic sw_in,
    output logic sw_out,
    output logic rise_out,
    output logic fall_out
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    deb_state_e             state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   commit;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in};
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    // With a one-cycle window the very first differing sample already qualifies.
    assign commit = (synced != level_q) &&
                    (((state_q == ST_STABLE) && (DEBOUNCE_CYCLES == 1)) ||
                     ((state_q == ST_PENDING) && (cnt_q == CNT_LAST)));

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (commit) begin
                level_q <= synced;
                rise_q  <= synced;
                fall_q  <= ~synced;
                cnt_q   <= '0;
                state_q <= ST_STABLE;
            end else begin
                case (state_q)
                    ST_STABLE: begin
                        if (synced != level_q) begin
                            state_q <= ST_PENDING;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    ST_PENDING: begin
                        if (synced == level_q) begin
                            state_q <= ST_STABLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_STABLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef DEBOUNCE_TOGGLE_EN
    logic toggle_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            toggle_q <= 1'b0;
        end else if (commit && synced) begin
            toggle_q <= ~toggle_q;
        end
    end

    assign sw_out = toggle_q;
`else
    assign sw_out = level_q;
`endif

    assign rise_out = rise_q;
    assign fall_out = fall_q;

endmodule

// File: rtl/input_debouncer.sv
// Multi-channel switch debouncer feeding the lab gate block; one debounce_ch per channel.
// Optional DEBOUNCE_TOGGLE_EN turns each sw_out bit into a push-button toggle.
module input_debouncer
    import lab_common_pkg::*;
#(
    parameter int NUM_CH          = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = SYNC_STAGES_DEF
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [NUM_CH-1:0] sw_in,
    output logic [NUM_CH-1:0] sw_out,
    output logic [NUM_CH-1:0] rise_out,
    output logic [NUM_CH-1:0] fall_out
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_ch (
            .clk_in  (clk_in),
            .rst_in  (rst_in),
            .sw_in   (sw_in[i]),
            .sw_out  (sw_out[i]),
            .rise_out(rise_out[i]),
            .fall_out(fall_out[i])
        );
    end

endmodule
